// File: rtl/add_approx_pipe_if.sv
// add_approx_pipe_if: operand/result valid-ready bundle for add_approx_pipe
interface add_approx_pipe_if #(parameter int WIDTH = 8);
  logic in_valid;
  logic in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [1:0] mode;
  logic out_valid;
  logic out_ready;
  logic [WIDTH:0] O;
  modport master (output in_valid, A, B, mode, out_ready, input in_ready, out_valid, O);
  modport slave (input in_valid, A, B, mode, out_ready, output in_ready, out_valid, O);
endinterface

// File: rtl/add_approx_pipe.sv
// add_approx_pipe: two-stage valid/ready approximate adder with error statistics
module add_approx_pipe #(
  parameter int WIDTH = 8,
  parameter int APPROX_BITS = 4,
  parameter int ACC_WIDTH = 32,
  parameter int CNT_WIDTH = 16
) (
  input  logic clk,
  input  logic rst,
  add_approx_pipe_if.slave bus,
  input  logic stat_clear,
  output logic [CNT_WIDTH-1:0] stat_cnt,
  output logic [ACC_WIDTH-1:0] stat_err_sum,
  output logic [WIDTH:0] stat_err_max
);
  localparam int KM1 = APPROX_BITS > 0 ? APPROX_BITS - 1 : 0;
  logic live, s1_valid, s2_adv, accept, fire, cin, approx_mode;
  logic [WIDTH-1:0] s1_a, s1_b;
  logic [1:0] s1_mode;
  logic [WIDTH:0] a_ext, b_ext, lo_mask, lo_part, hi_sum, approx, exact, e_reg, err;
  logic [ACC_WIDTH:0] sum_next;
  assign s2_adv = ~bus.out_valid | bus.out_ready;
  assign bus.in_ready = live & (~s1_valid | s2_adv);
  assign accept = bus.in_valid & bus.in_ready;
  assign fire = bus.out_valid & bus.out_ready;
  assign a_ext = {1'b0, s1_a};
  assign b_ext = {1'b0, s1_b};
  assign exact = a_ext + b_ext;
  assign lo_mask = ~({(WIDTH+1){1'b1}} << APPROX_BITS);
  assign cin = (APPROX_BITS > 0) && (s1_mode == 2'b01) && s1_a[KM1] && s1_b[KM1];
  assign lo_part = s1_mode == 2'b01 ? (a_ext | b_ext) & lo_mask : '0;
  assign hi_sum = (a_ext >> APPROX_BITS) + (b_ext >> APPROX_BITS) + {{WIDTH{1'b0}}, cin};
  assign approx = (hi_sum << APPROX_BITS) | lo_part;
  assign approx_mode = s1_mode == 2'b01 || s1_mode == 2'b10;
  assign err = bus.O >= e_reg ? bus.O - e_reg : e_reg - bus.O;
  assign sum_next = {1'b0, stat_err_sum} + (ACC_WIDTH+1)'(err);
  // in_ready stays low until the first edge after reset release
  always_ff @(posedge clk or posedge rst)
    if (rst) live <= 1'b0;
    else live <= 1'b1;
  // stage 1: capture operands and mode on acceptance
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      s1_valid <= 1'b0;
      s1_a <= '0;
      s1_b <= '0;
      s1_mode <= '0;
    end else if (accept) begin
      s1_valid <= 1'b1;
      s1_a <= bus.A;
      s1_b <= bus.B;
      s1_mode <= bus.mode;
    end else if (s2_adv) s1_valid <= 1'b0;
  // stage 2: register result and exact reference; hold while stalled
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      bus.out_valid <= 1'b0;
      bus.O <= '0;
      e_reg <= '0;
    end else if (s2_adv) begin
      bus.out_valid <= s1_valid;
      if (s1_valid) begin
        bus.O <= approx_mode ? approx : exact;
        e_reg <= exact;
      end
    end
  // error monitor: saturating count/sum and running max, clear has priority
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      stat_cnt <= '0;
      stat_err_sum <= '0;
      stat_err_max <= '0;
    end else if (stat_clear) begin
      stat_cnt <= '0;
      stat_err_sum <= '0;
      stat_err_max <= '0;
    end else if (fire) begin
      stat_cnt <= &stat_cnt ? stat_cnt : stat_cnt + CNT_WIDTH'(1);
      stat_err_sum <= sum_next[ACC_WIDTH] ? '1 : sum_next[ACC_WIDTH-1:0];
      stat_err_max <= err > stat_err_max ? err : stat_err_max;
    end
endmodule

// File: tb/tb_add_approx_pipe.sv
// tb_add_approx_pipe: randomized and directed checks of add_approx_pipe against a behavioural model
module tb_add_approx_pipe;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic stat_clear = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b1;
  logic [7:0] a = '0;
  logic [7:0] b = '0;
  logic [1:0] mode = '0;
  logic [15:0] cnt1;
  logic [31:0] sum1;
  logic [8:0] max1;
  logic [1:0] cnt2;
  logic [11:0] sum2;
  logic [8:0] max2;
  int n_cmp = 0;
  int n_bad = 0;
  int spurious = 0;
  longint ecnt1, esum1, emax1, ecnt2, esum2, emax2;
  typedef struct {int o1; int o2; int e;} exp_t;
  typedef struct {logic [8:0] g1; logic [8:0] g2; int w1; int w2;} obs_t;
  exp_t pend[$];
  obs_t obs[$];
  always #5 clk = ~clk;
  add_approx_pipe_if #(.WIDTH(8)) bus1 ();
  add_approx_pipe_if #(.WIDTH(8)) bus2 ();
  assign bus1.in_valid = in_valid;
  assign bus2.in_valid = in_valid;
  assign bus1.out_ready = out_ready;
  assign bus2.out_ready = out_ready;
  assign bus1.A = a;
  assign bus2.A = a;
  assign bus1.B = b;
  assign bus2.B = b;
  assign bus1.mode = mode;
  assign bus2.mode = mode;
  add_approx_pipe #(.WIDTH(8), .APPROX_BITS(4), .ACC_WIDTH(32), .CNT_WIDTH(16)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1.slave), .stat_clear(stat_clear),
    .stat_cnt(cnt1), .stat_err_sum(sum1), .stat_err_max(max1));
  add_approx_pipe #(.WIDTH(8), .APPROX_BITS(8), .ACC_WIDTH(12), .CNT_WIDTH(2)) dut2 (
    .clk(clk), .rst(rst), .bus(bus2.slave), .stat_clear(stat_clear),
    .stat_cnt(cnt2), .stat_err_sum(sum2), .stat_err_max(max2));

  // reference adder: split at 2^k, OR or zero the low part, add the high parts with an optional carry
  function automatic int model(int x, int y, int m, int k);
    int p, lo, cin;
    p = 1 << k;
    if (m != 1 && m != 2) return x + y;
    lo = 0;
    cin = 0;
    if (m == 1) begin
      lo = (x % p) | (y % p);
      if (k > 0) cin = ((x / (p / 2)) % 2) & ((y / (p / 2)) % 2);
    end
    return ((x / p) + (y / p) + cin) * p + lo;
  endfunction

  // scoreboard: records accepted operands and observed results; statistics model
  always @(negedge clk) begin
    exp_t x;
    longint e1, e2;
    if (rst) begin
      pend.delete();
      ecnt1 = 0; esum1 = 0; emax1 = 0; ecnt2 = 0; esum2 = 0; emax2 = 0;
    end else begin
      if (bus1.out_valid !== bus2.out_valid || bus1.in_ready !== bus2.in_ready) spurious++;
      if (bus1.out_valid && out_ready) begin
        if (pend.size() == 0) spurious++;
        else begin
          x = pend.pop_front();
          obs.push_back('{bus1.O, bus2.O, x.o1, x.o2});
          e1 = x.o1 > x.e ? x.o1 - x.e : x.e - x.o1;
          e2 = x.o2 > x.e ? x.o2 - x.e : x.e - x.o2;
          ecnt1 = ecnt1 == 65535 ? ecnt1 : ecnt1 + 1;
          esum1 = esum1 + e1 > 64'hFFFF_FFFF ? 64'hFFFF_FFFF : esum1 + e1;
          emax1 = e1 > emax1 ? e1 : emax1;
          ecnt2 = ecnt2 == 3 ? 3 : ecnt2 + 1;
          esum2 = esum2 + e2 > 4095 ? 4095 : esum2 + e2;
          emax2 = e2 > emax2 ? e2 : emax2;
        end
      end
      if (stat_clear) begin
        ecnt1 = 0; esum1 = 0; emax1 = 0; ecnt2 = 0; esum2 = 0; emax2 = 0;
      end
      if (in_valid && bus1.in_ready)
        pend.push_back('{model(int'(a), int'(b), int'(mode), 4), model(int'(a), int'(b), int'(mode), 8), int'(a) + int'(b)});
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({bus1.out_valid, bus1.O, cnt1, sum1, max1} !== '0) begin
      n_bad++;
      $display("FAIL reset_dut1 got ov=%0b O=%h cnt=%0d sum=%0d max=%0d want all 0", bus1.out_valid, bus1.O, cnt1, sum1, max1);
    end
    n_cmp++;
    if ({bus2.out_valid, bus2.O, cnt2, sum2, max2} !== '0) begin
      n_bad++;
      $display("FAIL reset_dut2 got ov=%0b O=%h cnt=%0d sum=%0d max=%0d want all 0", bus2.out_valid, bus2.O, cnt2, sum2, max2);
    end
    rst = 1'b0;
    cyc();
    n_cmp++;
    if (bus1.in_ready !== 1'b1 || bus2.in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_in_ready got %b/%b want 1/1", bus1.in_ready, bus2.in_ready);
    end
  endtask

  task automatic test_exact();
    a = 8'h37; b = 8'h29; mode = 2'b00; in_valid = 1'b1; out_ready = 1'b1;
    cyc();
    in_valid = 1'b0;
    n_cmp++;
    if (bus1.out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL exact_latency1 got out_valid=%b want 0", bus1.out_valid);
    end
    cyc();
    n_cmp++;
    if (bus1.out_valid !== 1'b1 || bus1.O !== 9'h060) begin
      n_bad++;
      $display("FAIL exact_dut1 got ov=%b O=%h want ov=1 O=060", bus1.out_valid, bus1.O);
    end
    n_cmp++;
    if (bus2.O !== 9'h060) begin
      n_bad++;
      $display("FAIL exact_dut2 got O=%h want 060", bus2.O);
    end
    cyc();
    n_cmp++;
    if (cnt1 !== 16'd1 || sum1 !== 32'd0 || max1 !== 9'd0) begin
      n_bad++;
      $display("FAIL exact_stats got cnt=%0d sum=%0d max=%0d want 1/0/0", cnt1, sum1, max1);
    end
    obs.delete();
  endtask

  task automatic test_approx();
    logic [7:0] ain [3] = '{8'h37, 8'hFF, 8'h37};
    logic [7:0] bin [3] = '{8'h29, 8'hFF, 8'h29};
    logic [1:0] md [3] = '{2'b01, 2'b01, 2'b10};
    logic [8:0] want1 [3] = '{9'h05F, 9'h1FF, 9'h050};
    obs_t o;
    stat_clear = 1'b1;
    cyc();
    stat_clear = 1'b0;
    for (int i = 0; i < 3; i++) begin
      a = ain[i]; b = bin[i]; mode = md[i]; in_valid = 1'b1;
      cyc();
    end
    in_valid = 1'b0;
    repeat (4) cyc();
    n_cmp++;
    if (obs.size() != 3) begin
      n_bad++;
      $display("FAIL approx_count got %0d results want 3", obs.size());
    end
    for (int i = 0; i < 3 && obs.size() > 0; i++) begin
      o = obs.pop_front();
      n_cmp++;
      if (o.g1 !== want1[i]) begin
        n_bad++;
        $display("FAIL approx_dut1[%0d] got %h want %h", i, o.g1, want1[i]);
      end
      n_cmp++;
      if (o.g2 !== 9'(o.w2)) begin
        n_bad++;
        $display("FAIL approx_dut2[%0d] got %h want %h", i, o.g2, 9'(o.w2));
      end
    end
    n_cmp++;
    if (cnt1 !== 16'd3 || sum1 !== 32'd18 || max1 !== 9'd16) begin
      n_bad++;
      $display("FAIL approx_stats1 got cnt=%0d sum=%0d max=%0d want 3/18/16", cnt1, sum1, max1);
    end
    n_cmp++;
    if (cnt2 !== 2'(ecnt2) || sum2 !== 12'(esum2) || max2 !== 9'(emax2)) begin
      n_bad++;
      $display("FAIL approx_stats2 got cnt=%0d sum=%0d max=%0d want %0d/%0d/%0d", cnt2, sum2, max2, ecnt2, esum2, emax2);
    end
  endtask

  task automatic test_clear();
    a = 8'h37; b = 8'h29; mode = 2'b10; in_valid = 1'b1; out_ready = 1'b1;
    cyc();
    in_valid = 1'b0;
    cyc();
    stat_clear = 1'b1;
    cyc();
    stat_clear = 1'b0;
    n_cmp++;
    if ({cnt1, sum1, max1, cnt2, sum2, max2} !== '0) begin
      n_bad++;
      $display("FAIL clear_wins got %0d/%0d/%0d %0d/%0d/%0d want all 0", cnt1, sum1, max1, cnt2, sum2, max2);
    end
    obs.delete();
  endtask

  task automatic test_saturation();
    stat_clear = 1'b1;
    cyc();
    stat_clear = 1'b0;
    a = 8'hFF; b = 8'hFF; mode = 2'b10; in_valid = 1'b1;
    repeat (10) cyc();
    in_valid = 1'b0;
    repeat (4) cyc();
    n_cmp++;
    if (cnt1 !== 16'd10 || sum1 !== 32'd300 || max1 !== 9'd30) begin
      n_bad++;
      $display("FAIL sat_stats1 got cnt=%0d sum=%0d max=%0d want 10/300/30", cnt1, sum1, max1);
    end
    n_cmp++;
    if (cnt2 !== 2'd3 || sum2 !== 12'd4095 || max2 !== 9'd510) begin
      n_bad++;
      $display("FAIL sat_stats2 got cnt=%0d sum=%0d max=%0d want 3/4095/510", cnt2, sum2, max2);
    end
    obs.delete();
  endtask

  task automatic test_backpressure();
    int accepts = 0;
    logic [8:0] held;
    logic [3:0] seq;
    obs_t o;
    out_ready = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      a = 8'($urandom); b = 8'($urandom); mode = 2'($urandom);
      @(negedge clk);
      if (in_valid && bus1.in_ready) accepts++;
      cyc();
    end
    n_cmp++;
    if (accepts != 2 || bus1.in_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL bp_accepts got %0d in_ready=%b want 2 in_ready=0", accepts, bus1.in_ready);
    end
    held = bus1.O;
    repeat (2) cyc();
    n_cmp++;
    if (bus1.O !== held || bus1.out_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL bp_hold got O=%h ov=%b want O=%h ov=1", bus1.O, bus1.out_valid, held);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      seq[i] = bus1.out_valid;
      cyc();
    end
    n_cmp++;
    if (seq !== 4'b0011 || obs.size() != 2) begin
      n_bad++;
      $display("FAIL bp_drain got seq=%b n=%0d want seq=0011 n=2", seq, obs.size());
    end
    while (obs.size() > 0) begin
      o = obs.pop_front();
      n_cmp++;
      if (o.g1 !== 9'(o.w1) || o.g2 !== 9'(o.w2)) begin
        n_bad++;
        $display("FAIL bp_order got %h/%h want %h/%h", o.g1, o.g2, 9'(o.w1), 9'(o.w2));
      end
    end
  endtask

  task automatic test_random();
    obs_t o;
    int bad = 0;
    for (int i = 0; i < 300; i++) begin
      in_valid = $urandom_range(0, 3) != 0;
      out_ready = $urandom_range(0, 3) != 0;
      stat_clear = $urandom_range(0, 29) == 0;
      a = 8'($urandom); b = 8'($urandom); mode = 2'($urandom);
      cyc();
    end
    in_valid = 1'b0; out_ready = 1'b1; stat_clear = 1'b0;
    repeat (4) cyc();
    n_cmp++;
    if (pend.size() != 0 || spurious != 0 || obs.size() < 50) begin
      n_bad++;
      $display("FAIL rand_flow got pending=%0d spurious=%0d results=%0d want 0/0/>=50", pend.size(), spurious, obs.size());
    end
    while (obs.size() > 0) begin
      o = obs.pop_front();
      n_cmp++;
      if (o.g1 !== 9'(o.w1) || o.g2 !== 9'(o.w2)) begin
        n_bad++;
        bad++;
        if (bad < 10) $display("FAIL rand_result got %h/%h want %h/%h", o.g1, o.g2, 9'(o.w1), 9'(o.w2));
      end
    end
    n_cmp++;
    if (cnt1 !== 16'(ecnt1) || sum1 !== 32'(esum1) || max1 !== 9'(emax1)) begin
      n_bad++;
      $display("FAIL rand_stats1 got %0d/%0d/%0d want %0d/%0d/%0d", cnt1, sum1, max1, ecnt1, esum1, emax1);
    end
    n_cmp++;
    if (cnt2 !== 2'(ecnt2) || sum2 !== 12'(esum2) || max2 !== 9'(emax2)) begin
      n_bad++;
      $display("FAIL rand_stats2 got %0d/%0d/%0d want %0d/%0d/%0d", cnt2, sum2, max2, ecnt2, esum2, emax2);
    end
  endtask

  task automatic test_reset_mid();
    a = 8'hFF; b = 8'hFF; mode = 2'b10; out_ready = 1'b1; in_valid = 1'b1;
    repeat (2) cyc();
    out_ready = 1'b0;
    repeat (3) cyc();
    in_valid = 1'b0;
    obs.delete();
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if ({bus1.out_valid, bus1.O, cnt1, sum1, max1, bus2.out_valid, cnt2, sum2, max2} !== '0) begin
      n_bad++;
      $display("FAIL midreset_clear got ov=%b O=%h cnt=%0d sum=%0d max=%0d want all 0", bus1.out_valid, bus1.O, cnt1, sum1, max1);
    end
    cyc();
    rst = 1'b0;
    out_ready = 1'b1;
    cyc();
    a = 8'h01; b = 8'h01; mode = 2'b00; in_valid = 1'b1;
    cyc();
    in_valid = 1'b0;
    n_cmp++;
    if (bus1.out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL midreset_partial got out_valid=%b want 0", bus1.out_valid);
    end
    cyc();
    n_cmp++;
    if (bus1.out_valid !== 1'b1 || bus1.O !== 9'h002 || bus2.O !== 9'h002) begin
      n_bad++;
      $display("FAIL midreset_new got ov=%b O=%h/%h want ov=1 O=002/002", bus1.out_valid, bus1.O, bus2.O);
    end
    repeat (2) cyc();
    n_cmp++;
    if (spurious != 0 || obs.size() != 1) begin
      n_bad++;
      $display("FAIL midreset_stream got spurious=%0d results=%0d want 0/1", spurious, obs.size());
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_exact();
    test_approx();
    test_clear();
    test_saturation();
    test_backpressure();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/add_approx_pipe.md
Name: add_approx_pipe

Overview:
- Parametrised, pipelined unsigned approximate adder. It is the successor to the fixed 8-bit combinational approximate adders in the library.
- The approximate low-part width is generic, and the arithmetic mode (exact / lower-part-OR / truncated) is selectable per transaction.
- It has a two-stage valid/ready pipeline and a built-in error monitor that accumulates sample count, absolute-error sum and maximum error against the exact sum.
- Used in characterisation and LUT-generation flows, and as a drop-in datapath adder.

Parameters:
- WIDTH, 8, operand width in bits (>=2).
- APPROX_BITS, 4, low-part width k subject to approximation (0..WIDTH). 0 makes every mode exact.
- ACC_WIDTH, 32, width of the error-sum accumulator.
- CNT_WIDTH, 16, width of the sample counter.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- in_valid  in  1  operand transaction valid.
- in_ready  out  1  block can accept an operand transaction.
- A  in  WIDTH  operand A, unsigned.
- B  in  WIDTH  operand B, unsigned.
- mode  in  2  00 exact, 01 LOA, 10 truncated, 11 reserved (treated as exact).
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- O  out  WIDTH+1  sum (approximate per mode), carry-out in MSB.
- stat_clear  in  1  synchronous clear of statistics.
- stat_cnt  out  CNT_WIDTH  accepted-result count, saturating.
- stat_err_sum  out  ACC_WIDTH  sum of |O - (A+B)|, saturating.
- stat_err_max  out  WIDTH+1  maximum |O - (A+B)| seen.

Behaviour:
- Reset: the async assert clears everything. out_valid=0, O=0, stat_cnt=0, stat_err_sum=0, stat_err_max=0, and the internal stage-1 valid=0. in_ready=1 one cycle after deassertion.
- Reset mid-operation: in-flight transactions are dropped with no partial output.
- Stage 1: A, B and mode are captured when in_valid & in_ready.
- Stage 2: the arithmetic is computed from the stage-1 registers and registered into O. The exact sum is registered alongside for the monitor.
- Latency: 2 cycles from input acceptance to out_valid. Throughput: 1 transaction/cycle when out_ready=1.
- Handshake:
  - s2 advance = ~out_valid | out_ready.
  - in_ready = ~s1_valid | s2_advance.
  - Transfer on valid & ready. O is held stable while out_valid & ~out_ready.
  - Order is preserved. No combinational path from in_valid to out_valid.
- Arithmetic, with k = APPROX_BITS and exact sum E = A + B (WIDTH+1 bits):
  - Exact: O = E.
  - LOA:
    - O[k-1:0] = A[k-1:0] | B[k-1:0].
    - cin = A[k-1] & B[k-1].
    - O[WIDTH:k] = A[WIDTH-1:k] + B[WIDTH-1:k] + cin.
  - Truncated: O[k-1:0] = 0, cin = 0, upper part as LOA.
  - k = WIDTH: the upper sum is empty. O[WIDTH] = cin.
  - k = 0: all modes equal exact.
- Error monitor: updates on each output transfer (out_valid & out_ready).
  - err = |O - E|.
  - stat_cnt += 1, saturating at all-ones.
  - stat_err_sum += err, saturating at all-ones.
  - stat_err_max = max(stat_err_max, err).
  - Stats update one cycle after the transfer.
- stat_clear: zeroes all stats on the next edge. If it coincides with a transfer, clear wins and that sample is not counted.

Test Plan:
- Exact mode: WIDTH=8, k=4, A=0x37, B=0x29, mode=00 -> O=0x060 two cycles after accept; err 0.
- LOA mode: A=0x37, B=0x29, mode=01 -> O=0x05F, err 1. A=0xFF, B=0xFF -> O=0x1FF (cin=1), err 1.
- Truncated mode: A=0x37, B=0x29, mode=10 -> O=0x050, err 16.
- Statistics and saturation:
  - The three approximate samples above -> stat_cnt=3, stat_err_sum=18, stat_err_max=16.
  - stat_clear -> all 0.
  - CNT_WIDTH=2 with 5 transfers -> stat_cnt holds 3.
- Backpressure: out_ready=0 with in_valid=1 continuously -> exactly 2 accepts, then in_ready=0 and O stable. Then out_ready=1 -> results emerge in order, one per cycle, none lost or duplicated.
- Reset mid-stream: assert rst with both stages full -> out_valid=0 and stats 0 immediately (async). After release, a new A=0x01, B=0x01 exact -> O=0x002 after 2 cycles.
